// File: rtl/bsg_chip_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bsg_chip_pkg
// Description : Shared types for chip-level reset/cord sequencing and the
//               router tag-client payload.
// Revision    : 1.0 - initial release
// ============================================================================
package bsg_chip_pkg;

    localparam int unsigned c_TAG_CORD_WIDTH = 7;

    typedef enum logic [2:0] {
        eAssert  = 3'd0,
        eCheck   = 3'd1,
        eRelease = 3'd2,
        eRun     = 3'd3,
        eError   = 3'd4
    } bsg_rst_seq_state_e;

    typedef struct packed {
        logic                        reset;
        logic [c_TAG_CORD_WIDTH-1:0] cord;
    } bp_tag_payload_s;

endpackage
`default_nettype wire

// File: rtl/bsg_cord_dup_check.sv
`default_nettype none
// ============================================================================
// Module      : bsg_cord_dup_check
// Description : Flags any two routers that share the same cord.
// Revision    : 1.0 - initial release
// ============================================================================
module bsg_cord_dup_check #(
    parameter int unsigned NUM_ROUTER_P = 4,
    parameter int unsigned CORD_WIDTH_P = 7
) (
    input  logic [NUM_ROUTER_P*CORD_WIDTH_P-1:0] cord_i,
    output logic                                 dup_o
);

    always_comb begin
        dup_o = 1'b0;
        for (int unsigned i = 0; i < NUM_ROUTER_P; i++) begin
            for (int unsigned j = i + 1; j < NUM_ROUTER_P; j++) begin
                if (cord_i[i*CORD_WIDTH_P +: CORD_WIDTH_P] == cord_i[j*CORD_WIDTH_P +: CORD_WIDTH_P]) begin
                    dup_o = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bsg_chip_reset_cord_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bsg_chip_reset_cord_sequencer
// Description : Collects router cords/resets and releases the reset domains
//               one at a time, each after a programmable delay.
// Revision    : 1.0 - initial release
// ============================================================================
module bsg_chip_reset_cord_sequencer
    import bsg_chip_pkg::*;
#(
    parameter int unsigned NUM_ROUTER_P  = 4,
    parameter int unsigned CORD_WIDTH_P  = 7,
    parameter int unsigned NUM_STAGES_P  = 3,
    parameter int unsigned DELAY_WIDTH_P = 8
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic [NUM_ROUTER_P-1:0]              tag_v_i,
    input  logic [NUM_ROUTER_P-1:0]              tag_reset_i,
    input  logic [NUM_ROUTER_P*CORD_WIDTH_P-1:0] tag_cord_i,
    input  logic [DELAY_WIDTH_P-1:0]             stage_delay_i,
    output logic [NUM_STAGES_P-1:0]              stage_reset_o,
    output logic [NUM_ROUTER_P*CORD_WIDTH_P-1:0] cord_o,
    output logic                                 cord_v_o,
    output logic                                 cord_err_o,
    output logic                                 done_o
);

    localparam int unsigned c_CORD_BITS = NUM_ROUTER_P * CORD_WIDTH_P;
    localparam int unsigned c_IDX_W     = (NUM_STAGES_P > 1) ? $clog2(NUM_STAGES_P) : 1;
    localparam logic [DELAY_WIDTH_P-1:0] c_DELAY_ONE = DELAY_WIDTH_P'(1);

    bsg_rst_seq_state_e          r_state, w_state_next;
    logic [DELAY_WIDTH_P-1:0]    r_cnt, w_cnt_next, w_delay;
    logic [c_IDX_W-1:0]          r_idx, w_idx_next;
    logic [NUM_STAGES_P-1:0]     r_stage_reset, w_stage_reset_next;
    logic                        r_cord_v, w_cord_v_next;
    logic                        r_cord_err, w_cord_err_next;
    logic                        r_done, w_done_next;
    logic [c_CORD_BITS-1:0]      r_cord;
    logic [NUM_ROUTER_P-1:0]     r_rst_req;
    logic [NUM_ROUTER_P-1:0]     r_cord_seen;
    logic                        w_tag_any;
    logic                        w_ready;
    logic                        w_dup;

    // Payload capture is independent of the sequencer state.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_cord      <= '0;
            r_rst_req   <= '1;
            r_cord_seen <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_ROUTER_P; i++) begin
                if (tag_v_i[i]) begin
                    r_cord[i*CORD_WIDTH_P +: CORD_WIDTH_P] <= tag_cord_i[i*CORD_WIDTH_P +: CORD_WIDTH_P];
                    r_rst_req[i]   <= tag_reset_i[i];
                    r_cord_seen[i] <= 1'b1;
                end
            end
        end
    end

    bsg_cord_dup_check #(
        .NUM_ROUTER_P (NUM_ROUTER_P),
        .CORD_WIDTH_P (CORD_WIDTH_P)
    ) u_dup_check (
        .cord_i (r_cord),
        .dup_o  (w_dup)
    );

    assign w_tag_any = |tag_v_i;
    assign w_ready   = (r_rst_req == '0) && (&r_cord_seen);
    assign w_delay   = (stage_delay_i == '0) ? c_DELAY_ONE : stage_delay_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state       <= eAssert;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_stage_reset <= '1;
            r_cord_v      <= 1'b0;
            r_cord_err    <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_idx         <= w_idx_next;
            r_stage_reset <= w_stage_reset_next;
            r_cord_v      <= w_cord_v_next;
            r_cord_err    <= w_cord_err_next;
            r_done        <= w_done_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_cnt_next         = r_cnt;
        w_idx_next         = r_idx;
        w_stage_reset_next = r_stage_reset;
        w_cord_v_next      = r_cord_v;
        w_cord_err_next    = r_cord_err;
        w_done_next        = r_done;

        case (r_state)
            eAssert: begin
                w_stage_reset_next = '1;
                if (r_cnt < w_delay) begin
                    w_cnt_next = r_cnt + c_DELAY_ONE;
                end
                if ((r_cnt >= w_delay) && w_ready) begin
                    w_state_next = eCheck;
                end
            end
            eCheck: begin
                if (w_dup) begin
                    w_state_next    = eError;
                    w_cord_err_next = 1'b1;
                end else begin
                    w_state_next          = eRelease;
                    w_idx_next            = '0;
                    w_cord_v_next         = 1'b1;
                    w_stage_reset_next[0] = 1'b0;
                    w_cnt_next            = '0;
                end
            end
            eRelease: begin
                if (r_cnt == (w_delay - c_DELAY_ONE)) begin
                    if (32'(r_idx) < (NUM_STAGES_P - 1)) begin
                        w_idx_next = r_idx + c_IDX_W'(1);
                        w_cnt_next = '0;
                        for (int unsigned i = 0; i < NUM_STAGES_P; i++) begin
                            if (i == (32'(r_idx) + 32'd1)) begin
                                w_stage_reset_next[i] = 1'b0;
                            end
                        end
                    end else begin
                        w_state_next = eRun;
                        w_done_next  = 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt + c_DELAY_ONE;
                end
            end
            eRun, eError: begin
            end
            default: begin
                w_state_next = eAssert;
            end
        endcase

        // A new payload from any router always restarts the hold from scratch.
        if (w_tag_any) begin
            w_state_next       = eAssert;
            w_cnt_next         = '0;
            w_idx_next         = '0;
            w_stage_reset_next = '1;
            w_cord_v_next      = 1'b0;
            w_cord_err_next    = 1'b0;
            w_done_next        = 1'b0;
        end
    end

    assign stage_reset_o = r_stage_reset;
    assign cord_o        = r_cord;
    assign cord_v_o      = r_cord_v;
    assign cord_err_o    = r_cord_err;
    assign done_o        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bsg_chip_reset_cord_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bsg_chip_reset_cord_sequencer
// Description : Directed plus randomized bench; expectations come from the
//               cycle count since the last payload and the captured config.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bsg_chip_reset_cord_sequencer;

    localparam int NR = 4;
    localparam int CW = 7;
    localparam int NS = 3;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              reset_i;
    logic [NR-1:0]     tag_v_i;
    logic [NR-1:0]     tag_reset_i;
    logic [NR*CW-1:0]  tag_cord_i;
    logic [DW-1:0]     stage_delay_i;
    logic [NS-1:0]     stage_reset_o;
    logic [NR*CW-1:0]  cord_o;
    logic              cord_v_o;
    logic              cord_err_o;
    logic              done_o;

    always #5 clk = ~clk;

    bsg_chip_reset_cord_sequencer #(
        .NUM_ROUTER_P  (NR),
        .CORD_WIDTH_P  (CW),
        .NUM_STAGES_P  (NS),
        .DELAY_WIDTH_P (DW)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .tag_v_i       (tag_v_i),
        .tag_reset_i   (tag_reset_i),
        .tag_cord_i    (tag_cord_i),
        .stage_delay_i (stage_delay_i),
        .stage_reset_o (stage_reset_o),
        .cord_o        (cord_o),
        .cord_v_o      (cord_v_o),
        .cord_err_o    (cord_err_o),
        .done_o        (done_o)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference state: captured payloads and cycles elapsed since the last event.
    int cord_m [NR];
    bit req_m  [NR];
    bit seen_m [NR];
    int age;
    int dm;

    function automatic logic [NR*CW-1:0] pack(input int c3, input int c2, input int c1, input int c0);
        return {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            cord_m[i] = 0;
            req_m[i]  = 1'b1;
            seen_m[i] = 1'b0;
        end
        age = 0;
    endtask

    task automatic check(input string tag);
        logic [NS-1:0]    e_stage;
        logic [NR*CW-1:0] e_cord;
        logic             e_v, e_err, e_done;
        bit               ready, dup, clean;
        int               rel;
        ready = 1'b1;
        dup   = 1'b0;
        for (int i = 0; i < NR; i++) begin
            if (!seen_m[i] || req_m[i]) ready = 1'b0;
            e_cord[i*CW +: CW] = CW'(cord_m[i]);
            for (int j = i + 1; j < NR; j++) begin
                if (cord_m[i] == cord_m[j]) dup = 1'b1;
            end
        end
        clean = ready && !dup;
        // hold of d cycles, one check cycle, then stage k drops k*d cycles later
        rel = dm + 2;
        for (int k = 0; k < NS; k++) begin
            e_stage[k] = !(clean && (age >= rel + k * dm));
        end
        e_v    = clean && (age >= rel);
        e_done = clean && (age >= rel + NS * dm);
        e_err  = ready && dup && (age >= rel);

        n_vec++;
        assert (stage_reset_o === e_stage) else begin
            n_err++;
            $error("FAIL %s stage_reset observed=%b expected=%b (age %0d)", tag, stage_reset_o, e_stage, age);
        end
        n_vec++;
        assert (cord_v_o === e_v) else begin
            n_err++;
            $error("FAIL %s cord_v observed=%b expected=%b (age %0d)", tag, cord_v_o, e_v, age);
        end
        n_vec++;
        assert (cord_err_o === e_err) else begin
            n_err++;
            $error("FAIL %s cord_err observed=%b expected=%b (age %0d)", tag, cord_err_o, e_err, age);
        end
        n_vec++;
        assert (done_o === e_done) else begin
            n_err++;
            $error("FAIL %s done observed=%b expected=%b (age %0d)", tag, done_o, e_done, age);
        end
        n_vec++;
        assert (cord_o === e_cord) else begin
            n_err++;
            $error("FAIL %s cord observed=%h expected=%h", tag, cord_o, e_cord);
        end
    endtask

    // Called just after a rising edge; drives inputs, advances one edge, checks.
    task automatic tick(input logic [NR-1:0] v, input logic [NR-1:0] rb,
                        input logic [NR*CW-1:0] cords, input int delay, input string tag);
        tag_v_i     = v;
        tag_reset_i = rb;
        tag_cord_i  = cords;
        if (v != '0) stage_delay_i = DW'(delay);
        @(posedge clk);
        #1;
        if (v != '0) begin
            age = 0;
            dm  = (delay == 0) ? 1 : delay;
            for (int i = 0; i < NR; i++) begin
                if (v[i]) begin
                    cord_m[i] = int'(cords[i*CW +: CW]);
                    req_m[i]  = rb[i];
                    seen_m[i] = 1'b1;
                end
            end
        end else begin
            age++;
        end
        tag_v_i = '0;
        check(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) tick('0, '0, '0, 0, tag);
    endtask

    // Pulse reset between edges and confirm outputs fall back without a clock.
    task automatic async_reset(input string tag);
        #2;
        reset_i = 1'b1;
        model_reset();
        #1;
        check(tag);
        #2;
        reset_i = 1'b0;
    endtask

    initial begin
        logic [NR-1:0]    rv, rrb;
        logic [NR*CW-1:0] rc;
        int               r;

        reset_i       = 1'b1;
        tag_v_i       = '0;
        tag_reset_i   = '0;
        tag_cord_i    = '0;
        stage_delay_i = DW'(4);
        dm            = 4;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_values");
        reset_i = 1'b0;

        // basic ordered release
        tick(4'hF, 4'h0, pack(3, 2, 1, 0), 4, "basic_send");
        idle(20, "basic_run");

        // reset request while running, then a fresh sequence
        tick(4'b0100, 4'b0100, pack(0, 2, 0, 0), 4, "rstreq_assert");
        idle(5, "rstreq_hold");
        tick(4'b0100, 4'b0000, pack(0, 2, 0, 0), 4, "rstreq_release");
        idle(20, "rstreq_run");

        // duplicate cord, then repair router 1
        tick(4'hF, 4'h0, pack(3, 2, 1, 1), 4, "dup_send");
        idle(12, "dup_hold");
        tick(4'b0010, 4'b0000, pack(0, 0, 5, 0), 4, "dup_fix");
        idle(20, "dup_fixed_run");

        // partial payload after a fresh reset
        async_reset("async_pre_partial");
        tick(4'b0111, 4'b0000, pack(0, 2, 1, 0), 4, "partial_send");
        idle(15, "partial_hold");
        tick(4'b1000, 4'b0000, pack(3, 0, 0, 0), 4, "partial_last");
        idle(20, "partial_run");

        // zero delay behaves as one
        tick(4'hF, 4'h0, pack(6, 5, 4, 3), 0, "zero_send");
        idle(8, "zero_run");

        // async reset while only the last stage is still held
        tick(4'hF, 4'h0, pack(3, 2, 1, 0), 4, "mid_send");
        idle(11, "mid_run");
        async_reset("async_mid_release");
        idle(10, "after_async");

        // randomized payload traffic
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                async_reset("rand_async");
            end
            if (r < 12) begin
                rv = ($urandom_range(0, 2) == 0) ? 4'hF : NR'($urandom);
                for (int i = 0; i < NR; i++) rrb[i] = ($urandom_range(0, 7) == 0);
                rc = pack(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
                tick(rv, rrb, rc, int'($urandom_range(0, 5)), "rand_event");
            end else begin
                tick('0, '0, '0, 0, "rand_idle");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
